// File: rtl/tetris_sequencer.sv
// Game-phase sequencer for a 4x8 falling-block game.
// It tracks the game phase, picks the next piece from an LFSR, generates gravity
// strobes, and counts cleared rows and score.
// Optional build macro TETRIS_PAUSE_EN: when defined, pause=1 freezes the MOVE phase.
module tetris_sequencer #(
   parameter int unsigned DROP_DIV = 16
) (
   input  logic        clka,
   input  logic        restart_n,
   input  logic        start,
   input  logic        landed,
   input  logic        error,
   input  logic [31:0] board_in,
   input  logic        pause,
   output logic [2:0]  state,
   output logic [1:0]  curr_piece,
   output logic        drop_pulse,
   output logic [7:0]  lines,
   output logic [9:0]  score,
   output logic        game_over
);

   localparam int unsigned CNT_W     = 8;
   localparam int unsigned LINES_W   = 8;
   localparam int unsigned SCORE_W   = 10;
   localparam int unsigned ROWS      = 8;
   localparam logic [CNT_W-1:0] DIV  = CNT_W'(DROP_DIV);
   localparam logic [7:0]  LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      GEN      = 3'd0,
      MOVE     = 3'd1,
      CLEAR    = 3'd2,
      NEWBOARD = 3'd4,
      OVER     = 3'd5
   } state_t;

   state_t             state_q, state_n;
   logic [1:0]         sync_q;
   logic               run_c;
   logic [7:0]         lfsr_q, lfsr_n;
   logic [1:0]         piece_q, piece_n;
   logic               pulse_q, pulse_n;
   logic [LINES_W-1:0] lines_q, lines_n;
   logic [SCORE_W-1:0] score_q, score_n;
   logic               over_q, over_n;
   logic [CNT_W-1:0]   drop_q, drop_n;
   logic               gen_q, gen_n;
   logic [2:0]         clr_q, clr_n;
   logic               first_q, first_n;

   logic [ROWS-1:0]    full_c;
   logic [2:0]         hi_c;
   logic               any_full_c;
   logic               two_c;
   logic [LINES_W:0]   lines_sum_c;
   logic [SCORE_W:0]   score_sum_c;
   logic               paused_c;

`ifdef TETRIS_PAUSE_EN
   assign paused_c = pause && (state_q == MOVE);
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign paused_c     = 1'b0;
`endif

   // Reset release synchronizer; logic runs once the release has crossed two flops.
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) sync_q <= 2'b00;
      else            sync_q <= {sync_q[0], 1'b1};
   end

   assign run_c = sync_q[1];

   // Full-row detection and the size of the clear taken this cycle.
   always_comb begin
      full_c      = '0;
      hi_c        = 3'd0;
      any_full_c  = 1'b0;
      two_c       = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         full_c[r] = (board_in[4*r +: 4] == 4'hF);
         if (full_c[r]) begin
            hi_c       = 3'(r);
            any_full_c = 1'b1;
         end
      end
      if (any_full_c && (hi_c != 3'd0)) two_c = full_c[hi_c - 3'd1];
      lines_sum_c = {1'b0, lines_q} + (two_c ? 9'd2 : 9'd1);
      score_sum_c = {1'b0, score_q} + (two_c ? 11'd3 : 11'd1);
   end

   // Phase register and all registered outputs.
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q <= NEWBOARD;
         lfsr_q  <= LFSR_SEED;
         piece_q <= 2'd0;
         pulse_q <= 1'b0;
         lines_q <= '0;
         score_q <= '0;
         over_q  <= 1'b0;
         drop_q  <= '0;
         gen_q   <= 1'b0;
         clr_q   <= 3'd0;
         first_q <= 1'b0;
      end else if (run_c) begin
         state_q <= state_n;
         lfsr_q  <= lfsr_n;
         piece_q <= piece_n;
         pulse_q <= pulse_n;
         lines_q <= lines_n;
         score_q <= score_n;
         over_q  <= over_n;
         drop_q  <= drop_n;
         gen_q   <= gen_n;
         clr_q   <= clr_n;
         first_q <= first_n;
      end
   end

   // Next-phase, counter and output decode.
   always_comb begin
      state_n = state_q;
      lfsr_n  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      piece_n = piece_q;
      pulse_n = 1'b0;
      lines_n = lines_q;
      score_n = score_q;
      drop_n  = drop_q;
      gen_n   = gen_q;
      clr_n   = clr_q;
      first_n = first_q;

      case (state_q)
         NEWBOARD: if (start) state_n = GEN;
         GEN: begin
            if (gen_q) state_n = MOVE;
            else       gen_n   = 1'b1;
         end
         MOVE: begin
            if (!paused_c) begin
               first_n = 1'b0;
               if (first_q && error) begin
                  state_n = OVER;
               end else if (landed) begin
                  state_n = CLEAR;
               end else begin
                  drop_n  = (drop_q == DIV) ? CNT_W'(1) : drop_q + CNT_W'(1);
                  pulse_n = (drop_n == DIV);
               end
            end
         end
         CLEAR: begin
            if (any_full_c) begin
               lines_n = (lines_sum_c > 9'd255) ? 8'd255 : lines_sum_c[LINES_W-1:0];
               score_n = (score_sum_c > 11'd1023) ? 10'd1023 : score_sum_c[SCORE_W-1:0];
            end
            if (!any_full_c || (clr_q == 3'd7)) state_n = GEN;
            else                                 clr_n   = clr_q + 3'd1;
         end
         OVER:    if (start) state_n = NEWBOARD;
         default: state_n = NEWBOARD;
      endcase

      // Entry actions; drop_q holds the 1-based index of the current MOVE cycle.
      if (state_n != state_q) begin
         case (state_n)
            GEN: begin
               gen_n   = 1'b0;
               piece_n = lfsr_q[1:0];
            end
            MOVE: begin
               drop_n  = CNT_W'(1);
               first_n = 1'b1;
            end
            CLEAR: clr_n = 3'd0;
            NEWBOARD: begin
               lines_n = '0;
               score_n = '0;
            end
            default: ;
         endcase
      end
      over_n = (state_n == OVER);
   end

   assign state      = state_q;
   assign curr_piece = piece_q;
   assign drop_pulse = pulse_q;
   assign lines      = lines_q;
   assign score      = score_q;
   assign game_over  = over_q;

endmodule

// File: tb/tb_tetris_sequencer.sv
// Directed bench for tetris_sequencer (DROP_DIV=16).
module tb_tetris_sequencer;

   logic        clka = 1'b0;
   logic        restart_n = 1'b0;
   logic        start = 1'b0;
   logic        landed = 1'b0;
   logic        error = 1'b0;
   logic [31:0] board_in = 32'h0;
   logic        pause = 1'b0;
   logic [2:0]  state;
   logic [1:0]  curr_piece;
   logic        drop_pulse;
   logic [7:0]  lines;
   logic [9:0]  score;
   logic        game_over;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_pulse;

   tetris_sequencer #(.DROP_DIV(16)) dut (
      .clka(clka), .restart_n(restart_n), .start(start), .landed(landed),
      .error(error), .board_in(board_in), .pause(pause), .state(state),
      .curr_piece(curr_piece), .drop_pulse(drop_pulse), .lines(lines),
      .score(score), .game_over(game_over)
   );

   always #5 clka = ~clka;

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef TETRIS_PAUSE_EN
      exp_pulse = 26;
`else
      exp_pulse = 16;
`endif
      #12;
      // reset values
      chk("rst_state", 32'(state), 32'd4);
      chk("rst_piece", 32'(curr_piece), 32'd0);
      chk("rst_pulse", 32'(drop_pulse), 32'd0);
      chk("rst_lines", 32'(lines), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);

      // release reset with start held: two synchronizer edges, then GEN
      tick();
      restart_n = 1'b1;
      start = 1'b1;
      tick(); chk("sync_e1", 32'(state), 32'd4);
      tick(); chk("sync_e2", 32'(state), 32'd4);
      tick(); chk("gen1", 32'(state), 32'd0);
      chk("piece_a5", 32'(curr_piece), 32'd1);
      start = 1'b0;
      tick(); chk("gen2", 32'(state), 32'd0);
      tick(); chk("move1", 32'(state), 32'd1);

      // gravity strobes on MOVE cycles 16 and 32
      for (int c = 1; c <= 40; c++) begin
         chk($sformatf("pulse_c%0d", c), 32'(drop_pulse), 32'((c == 16) || (c == 32)));
         tick();
      end
      chk("still_move", 32'(state), 32'd1);
      chk("piece_held", 32'(curr_piece), 32'd1);

      // double clear of rows 7 and 6
      board_in = 32'hFF00_0000;
      landed = 1'b1;
      tick(); chk("to_clear", 32'(state), 32'd2);
      chk("clear_pulse", 32'(drop_pulse), 32'd0);
      landed = 1'b0;
      tick(); chk("dbl_lines", 32'(lines), 32'd2);
      chk("dbl_score", 32'(score), 32'd3);
      chk("dbl_state", 32'(state), 32'd2);
      board_in = 32'h0;
      tick(); chk("clear_exit", 32'(state), 32'd0);

      // spawn collision wins over landed
      tick(); tick(); chk("move_again", 32'(state), 32'd1);
      error = 1'b1;
      landed = 1'b1;
      tick(); chk("over_state", 32'(state), 32'd5);
      chk("over_flag", 32'(game_over), 32'd1);
      chk("over_lines", 32'(lines), 32'd2);
      chk("over_score", 32'(score), 32'd3);
      error = 1'b0;
      landed = 1'b0;
      start = 1'b1;
      tick(); chk("newboard", 32'(state), 32'd4);
      chk("nb_lines", 32'(lines), 32'd0);
      chk("nb_score", 32'(score), 32'd0);
      chk("nb_over", 32'(game_over), 32'd0);
      tick(); chk("nb_gen", 32'(state), 32'd0);
      start = 1'b0;

      // clear guard: a stuck full row leaves CLEAR after 8 cycles
      tick(); tick(); chk("move3", 32'(state), 32'd1);
      board_in = 32'h000F_0000;
      landed = 1'b1;
      tick(); chk("clear3", 32'(state), 32'd2);
      landed = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("guard_state%0d", i), 32'(state), (i == 8) ? 32'd0 : 32'd2);
         chk($sformatf("guard_lines%0d", i), 32'(lines), 32'(i));
         chk($sformatf("guard_score%0d", i), 32'(score), 32'(i));
      end

      // pause across MOVE cycles 6..15
      board_in = 32'h0;
      tick(); tick(); chk("move4", 32'(state), 32'd1);
      for (int c = 1; c <= 30; c++) begin
         pause = (c >= 6) && (c <= 15);
         chk($sformatf("pause_c%0d", c), 32'(drop_pulse), 32'(c == exp_pulse));
         tick();
      end
      pause = 1'b0;
      chk("move5", 32'(state), 32'd1);

      // 320 single clears: lines saturate, score does not
      board_in = 32'h000F_0000;
      landed = 1'b1;
      for (int r = 0; r < 40; r++) repeat (11) tick();
      chk("sat_state", 32'(state), 32'd1);
      chk("sat_lines", 32'(lines), 32'd255);
      chk("sat_score1", 32'(score), 32'd328);

      // 30 rounds of double clears: score saturates
      board_in = 32'hFF00_0000;
      for (int r = 0; r < 30; r++) repeat (11) tick();
      chk("sat_score2", 32'(score), 32'd1023);
      chk("sat_lines2", 32'(lines), 32'd255);
      landed = 1'b0;
      board_in = 32'h0;

      // asynchronous reset mid-cycle
      #2 restart_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd4);
      chk("arst_lines", 32'(lines), 32'd0);
      chk("arst_score", 32'(score), 32'd0);
      chk("arst_piece", 32'(curr_piece), 32'd0);
      chk("arst_pulse", 32'(drop_pulse), 32'd0);
      tick();
      restart_n = 1'b1;
      tick(); tick(); tick();
      chk("idle_nb", 32'(state), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tetris_sequencer.md
TETRIS_SEQUENCER -- requirements
Module: tetris_sequencer

Interface
REQ-001 Parameter DROP_DIV, default 16: clka cycles between gravity pulses in MOVE (legal range 2..255).
REQ-002 Ports (one per line: name, direction, width, meaning):
- clka  in  1  single system clock, rising-edge.
- restart_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves NEWBOARD or OVER.
- landed  in  1  mover reports piece at rest, sampled in MOVE.
- error  in  1  spawn-collision flag from clear_redraw.
- board_in  in  32  current board; 8 rows of 4 bits; row 7 = [31:28], row 0 = [3:0].
- pause  in  1  freeze request; used only with TETRIS_PAUSE_EN.
- state  out  3  phase code to mover and clear_redraw.
- curr_piece  out  2  piece id for clear_redraw.
- drop_pulse  out  1  one-cycle gravity strobe.
- lines  out  8  total rows cleared, saturating at 255.
- score  out  10  saturating at 1023.
- game_over  out  1  high while in OVER.

Function
REQ-003 State encodings on `state`: GEN=0, MOVE=1, CLEAR=2, NEWBOARD=4, OVER=5; codes 3, 6 and 7 are never driven.
REQ-004 NEWBOARD: go to GEN when start=1, else stay.
REQ-005 GEN lasts exactly 2 cycles, then MOVE.
REQ-006 curr_piece loads lfsr[1:0] on the clock edge entering GEN and is held constant until the next GEN entry.
REQ-007 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle in all states, never all-zero.
REQ-008 First MOVE cycle: if error=1, go to OVER; error is ignored in all other cycles.
REQ-009 MOVE: drop counter clears on MOVE entry; drop_pulse=1 for one cycle every DROP_DIV cycles. First pulse occurs on MOVE cycle DROP_DIV.
REQ-010 MOVE with landed=1 (and no OVER transition): go to CLEAR next cycle. drop_pulse=0 in that cycle.
REQ-011 Full row: a board_in row nibble equal to 4'hF.
REQ-012 Each CLEAR cycle with at least one full row:
- n=2 if the highest-index full row and the row directly below it are both full, else n=1.
- lines += n.
- score += 1 if n=1, += 3 if n=2.
- Both counters saturate.
REQ-013 CLEAR exit: go to GEN when board_in has no full row. CLEAR also exits to GEN after 8 consecutive CLEAR cycles, as a guard.
REQ-014 OVER: game_over=1; lines and score hold. start=1 goes to NEWBOARD, which clears lines and score.
REQ-015 drop_pulse=0 outside MOVE.
REQ-016 Simultaneous events in MOVE: OVER has priority over landed. landed has priority over drop_pulse.
REQ-017 All outputs are registered; no combinational path from input to output.

Reset
REQ-018 restart_n=0 asynchronously forces:
- state=NEWBOARD, curr_piece=0, drop_pulse=0, lines=0, score=0, game_over=0.
- lfsr=8'hA5; drop counter=0; GEN and CLEAR counters=0.
REQ-019 Reset asserted mid-game aborts immediately. Deassertion is synchronized internally, so the first active edge occurs 2 clka edges after release.

Configuration
REQ-020 Macro TETRIS_PAUSE_EN, when defined:
- pause=1 in MOVE freezes the FSM and the drop counter and holds drop_pulse=0.
- landed and error are ignored while paused.
- The LFSR keeps running.
- Releasing pause resumes counting from the frozen value.
REQ-021 TETRIS_PAUSE_EN undefined: the pause port exists but is ignored; behaviour is identical to pause=0.

Verification
REQ-022 Reset, then start=1 -> state sequence 4,0,0,1; curr_piece equals bits[1:0] of the LFSR value 2 edges after reset release.
REQ-023 DROP_DIV=16, MOVE held 40 cycles with landed=0 -> drop_pulse high on MOVE cycles 16 and 32 only.
REQ-024 landed=1 with board_in=32'hFF00_0000 -> CLEAR; lines=2, score=3. Then board_in=0 -> GEN the next cycle.
REQ-025 error=1 on first MOVE cycle, with landed=1 in the same cycle -> state=5, game_over=1. Then start=1 -> state=4, lines=0, score=0.
REQ-026 board_in held at 32'h000F_0000 in CLEAR -> exactly 8 CLEAR cycles, lines=8, score=8, then GEN. Saturation check: 300 forced single clears -> lines=255.
REQ-027 TETRIS_PAUSE_EN defined, pause=1 for 10 cycles after MOVE cycle 5 -> first drop_pulse on cycle 26 of MOVE residence. Macro undefined -> first drop_pulse on cycle 16.
